// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: active-low segment
// patterns ({g,f,e,d,c,b,a}), anode idle value and digit count.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] ALL_ANODES_OFF = 4'hF;

  // Active-low one-hot anode for a digit index.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode display scanner with per-frame digit snapshot and
// leading-zero blanking. Define SEG_BLINK_EN to add the blink port and blink timer.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] s3,
  input  logic [3:0] dp_pos,
  input  logic       lz_blank,
`ifdef SEG_BLINK_EN
  input  logic       blink,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]             cnt;
  logic [1:0]                idx;
  logic [4*NUM_DIGITS-1:0]   snap;
  logic                      digit_end;
  logic                      frame_end;
  logic [3:0]                nib;
  logic [6:0]                dec_seg;
  logic [3:1]                upper_zero;
  logic                      blank;
  logic                      dark;

  assign digit_end = (cnt == CNT_LAST);
  assign frame_end = digit_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
    end else begin
      if (digit_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Inputs are captured only here so a frame never mixes two counter values.
      if (frame_end)
        snap <= {s3, s2, s1, s0};
    end
  end

  always_comb begin
    nib = snap[3:0];
    case (idx)
      2'd0: nib = snap[3:0];
      2'd1: nib = snap[7:4];
      2'd2: nib = snap[11:8];
      2'd3: nib = snap[15:12];
      default: nib = snap[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .code (nib),
    .seg  (dec_seg)
  );

  // upper_zero[i]: digit i and every more-significant digit hold code 0.
  assign upper_zero[3] = (snap[15:12] == 4'd0);
  assign upper_zero[2] = upper_zero[3] && (snap[11:8] == 4'd0);
  assign upper_zero[1] = upper_zero[2] && (snap[7:4] == 4'd0);

  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1: blank = upper_zero[1];
      2'd2: blank = upper_zero[2];
      2'd3: blank = upper_zero[3];
      default: blank = 1'b0;
    endcase
    blank = blank && lz_blank;
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  logic [BW-1:0] scan_cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      phase    <= 1'b0;
    end else if (frame_end) begin
      if (!blink) begin
        scan_cnt <= '0;
        phase    <= 1'b0;
      end else if (scan_cnt == BLINK_LAST) begin
        scan_cnt <= '0;
        phase    <= ~phase;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign dark = blink && phase;
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= ALL_ANODES_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an <= anode_for(idx);
      if (blank || dark) begin
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        seg <= dec_seg;
        dp  <= ~dp_pos[idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (REFRESH_DIV=4, BLINK_SCANS=2); blink
// sequence is included when SEG_BLINK_EN is defined.
module tb_seven_seg_scan;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] P0   = 7'b1000000;
  localparam logic [6:0] P1   = 7'b1111001;
  localparam logic [6:0] P2   = 7'b0100100;
  localparam logic [6:0] P3   = 7'b0110000;
  localparam logic [6:0] P4   = 7'b0011001;
  localparam logic [6:0] P5   = 7'b0010010;
  localparam logic [6:0] P6   = 7'b0000010;
  localparam logic [6:0] P7   = 7'b1111000;
  localparam logic [6:0] P8   = 7'b0000000;
  localparam logic [6:0] P9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic       clk;
  logic       reset_n;
  logic [3:0] s0, s1, s2, s3;
  logic [3:0] dp_pos;
  logic       lz_blank;
`ifdef SEG_BLINK_EN
  logic       blink;
`endif
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_scan #(
    .REFRESH_DIV (RD),
    .BLINK_SCANS (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .dp_pos   (dp_pos),
    .lz_blank (lz_blank),
`ifdef SEG_BLINK_EN
    .blink    (blink),
`endif
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [3:0] s3, s2, s1, s0;
    logic       lz;
    logic [3:0] dpp;
    logic [6:0] d0, d1, d2, d3;
    logic [3:0] xdp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] an_x,
                       input logic [6:0] seg_x, input logic dp_x);
    checks++;
    if (an !== an_x || seg !== seg_x || dp !== dp_x) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, an, seg, dp, an_x, seg_x, dp_x);
    end
  endtask

  // Expected frame: digit 0..3, each lit for RD cycles.
  task automatic push_frame(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3,
                            input logic [3:0] xdp);
    logic [3:0] one;
    logic [6:0] segs [4];
    exp_t       e;
    one = 4'b0001;
    segs[0] = d0; segs[1] = d1; segs[2] = d2; segs[3] = d3;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < RD; k++) begin
        e.an  = ~(one << i);
        e.seg = segs[i];
        e.dp  = xdp[i];
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      tick();
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: scoreboard empty at cycle %0d, got an=%b seg=%b dp=%b",
                 name, k, an, seg, dp);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s[%0d]", name, k), e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0);
    s3 = a3; s2 = a2; s1 = a1; s0 = a0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //                s3    s2    s1    s0    lz    dp_pos   d0    d1    d2    d3    xdp
    vecs[0]  = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'b0000, P4,   P3,   P2,   P1,   4'b1111};
    vecs[1]  = '{4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 4'b0000, P0,   P5,   OFF,  OFF,  4'b1111};
    vecs[2]  = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0000, P0,   OFF,  OFF,  OFF,  4'b1111};
    vecs[3]  = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000, P0,   P0,   P0,   P0,   4'b1111};
    vecs[4]  = '{4'd0, 4'd0, 4'hC, 4'd0, 1'b0, 4'b0100, P0,   DASH, P0,   P0,   4'b1011};
    vecs[5]  = '{4'd0, 4'd0, 4'hC, 4'd0, 1'b1, 4'b0101, P0,   DASH, OFF,  OFF,  4'b1110};
    vecs[6]  = '{4'd9, 4'd8, 4'd7, 4'd6, 1'b1, 4'b1010, P6,   P7,   P8,   P9,   4'b0101};
    vecs[7]  = '{4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0000, P0,   P0,   P0,   DASH, 4'b1111};
    vecs[8]  = '{4'd0, 4'hA, 4'd0, 4'd0, 1'b1, 4'b1111, P0,   P0,   DASH, OFF,  4'b1000};
    vecs[9]  = '{4'd0, 4'd0, 4'd0, 4'hE, 1'b1, 4'b1111, DASH, OFF,  OFF,  OFF,  4'b1110};
    vecs[10] = '{4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 4'b0010, P0,   P0,   P1,   OFF,  4'b1101};

    reset_n  = 1'b0;
    lz_blank = 1'b0;
    dp_pos   = 4'b0000;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
`ifdef SEG_BLINK_EN
    blink = 1'b0;
`endif

    // Reset holds every output dark.
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("reset[%0d]", k), 4'hF, OFF, 1'b1);
    end

    // Before the first snapshot the display shows snap=0 ("   0" with blanking).
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    lz_blank = 1'b1;
    reset_n  = 1'b1;
    push_frame(P0, OFF, OFF, OFF, 4'b1111);
    drain("frame0", FRAME);

    // Table: inputs held for one frame to be captured, then the next frame checked.
    for (int v = 0; v < 11; v++) begin
      set_digits(vecs[v].s3, vecs[v].s2, vecs[v].s1, vecs[v].s0);
      lz_blank = vecs[v].lz;
      dp_pos   = vecs[v].dpp;
      repeat (FRAME) tick();
      push_frame(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].xdp);
      drain($sformatf("vec%0d", v), FRAME);
    end

    // Mid-frame input change must not reach the display until the next wrap.
    set_digits(4'd0, 4'd0, 4'd2, 4'd3);
    lz_blank = 1'b0;
    dp_pos   = 4'b0000;
    repeat (FRAME) tick();
    push_frame(P3, P2, P0, P0, 4'b1111);
    drain("snap_hold_d0", RD);
    s1 = 4'd9;
    s0 = 4'd7;
    drain("snap_hold_rest", FRAME - RD);
    push_frame(P7, P9, P0, P0, 4'b1111);
    drain("snap_new_a", FRAME);
    push_frame(P7, P9, P0, P0, 4'b1111);
    drain("snap_new_b", FRAME);

    // Reset asserted mid-scan (digit 2) clears everything at the next edge.
    set_digits(4'd5, 4'd5, 4'd5, 4'd5);
    repeat (2 * RD + 1) tick();
    reset_n = 1'b0;
    tick();
    check("midreset_a", 4'hF, OFF, 1'b1);
    tick();
    check("midreset_b", 4'hF, OFF, 1'b1);
    reset_n = 1'b1;
    tick();
    check("post_reset_first", 4'b1110, P0, 1'b1);
    repeat (FRAME - 1) tick();
    push_frame(P5, P5, P5, P5, 4'b1111);
    drain("post_reset_frame", FRAME);

`ifdef SEG_BLINK_EN
    // Blink: two scans lit, two dark, anodes keep scanning; blink=0 clears phase.
    reset_n = 1'b0;
    tick();
    set_digits(4'd8, 4'd8, 4'd8, 4'd8);
    lz_blank = 1'b0;
    dp_pos   = 4'b0001;
    blink    = 1'b1;
    reset_n  = 1'b1;
    push_frame(P0, P0, P0, P0, 4'b1110);
    drain("blink_f0", FRAME);
    push_frame(P8, P8, P8, P8, 4'b1110);
    drain("blink_f1", FRAME);
    push_frame(OFF, OFF, OFF, OFF, 4'b1111);
    drain("blink_f2", FRAME);
    push_frame(OFF, OFF, OFF, OFF, 4'b1111);
    drain("blink_f3", FRAME);
    push_frame(P8, P8, P8, P8, 4'b1110);
    drain("blink_f4", FRAME);
    blink = 1'b0;
    push_frame(P8, P8, P8, P8, 4'b1110);
    drain("blink_f5", FRAME);
    blink = 1'b1;
    push_frame(P8, P8, P8, P8, 4'b1110);
    drain("blink_f6", FRAME);
    push_frame(P8, P8, P8, P8, 4'b1110);
    drain("blink_f7", FRAME);
    push_frame(OFF, OFF, OFF, OFF, 4'b1111);
    drain("blink_f8", FRAME);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
